// File: rtl/maindec_mc.sv
// maindec_mc: multicycle LEGv8 main control FSM; accepts one opcode per instr_valid/instr_ready handshake.
// Latency to IDLE: R 3, LDUR 4+wait, STUR 3+wait, branch/illegal 2; memory states hold until mem_ready when MEM_WAIT=1.
module maindec_mc #(
  parameter bit MEM_WAIT = 1'b1,
  parameter bit EN_CBNZ  = 1'b1,
  parameter bit EN_B     = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [10:0]      Op,
  input  logic             mem_ready,
  output logic             instr_ready,
  output logic             IRWrite,
  output logic             Reg2Loc,
  output logic             ALUSrc,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             Branch,
  output logic [1:0]       ALUOp,
  output logic             BranchNZ,
  output logic             UncondBranch,
  output logic             PCWrite,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    st_idle,
    st_decode,
    st_exec_r,
    st_wb_r,
    st_addr,
    st_mem_rd,
    st_wb_ld,
    st_mem_wr,
    st_br,
    st_ill
  } state_t;

  localparam logic [10:0] op_ldur = 11'b11111000010;
  localparam logic [10:0] op_stur = 11'b11111000000;
  localparam logic [10:0] op_add  = 11'b10001011000;
  localparam logic [10:0] op_sub  = 11'b11001011000;
  localparam logic [10:0] op_and  = 11'b10001010000;
  localparam logic [10:0] op_orr  = 11'b10101010000;

  state_t      state_q;
  state_t      state_d;
  logic [10:0] op_q;
  logic        retire;

  logic is_rtype;
  logic is_ldur;
  logic is_stur;
  logic is_cbz;
  logic is_cbnz;
  logic is_b;
  logic mem_go;

  // Classification always works from the latched opcode, never from the live Op bus.
  assign is_rtype = (op_q == op_add) || (op_q == op_sub) ||
                    (op_q == op_and) || (op_q == op_orr);
  assign is_ldur  = (op_q == op_ldur);
  assign is_stur  = (op_q == op_stur);
  assign is_cbz   = (op_q[10:3] == 8'b10110100);
  assign is_cbnz  = EN_CBNZ && (op_q[10:3] == 8'b10110101);
  assign is_b     = EN_B && (op_q[10:5] == 6'b000101);
  assign mem_go   = mem_ready || !MEM_WAIT;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= st_idle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q    <= '0;
      retired <= '0;
    end else begin
      if (state_q == st_idle && instr_valid) begin
        op_q <= Op;
      end
      if (retire) begin
        retired <= retired + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    instr_ready  = 1'b0;
    IRWrite      = 1'b0;
    Reg2Loc      = 1'b0;
    ALUSrc       = 1'b0;
    MemtoReg     = 1'b0;
    RegWrite     = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    Branch       = 1'b0;
    ALUOp        = 2'b00;
    BranchNZ     = 1'b0;
    UncondBranch = 1'b0;
    PCWrite      = 1'b0;
    illegal      = 1'b0;
    retire       = 1'b0;

    case (state_q)
      st_idle: begin
        instr_ready = 1'b1;
        IRWrite     = instr_valid;
        if (instr_valid) begin
          state_d = st_decode;
        end
      end
      st_decode: begin
        if (is_rtype) begin
          state_d = st_exec_r;
        end else if (is_ldur || is_stur) begin
          state_d = st_addr;
        end else if (is_cbz || is_cbnz || is_b) begin
          state_d = st_br;
        end else begin
          state_d = st_ill;
        end
      end
      st_exec_r: begin
        ALUOp   = 2'b10;
        state_d = st_wb_r;
      end
      st_wb_r: begin
        ALUOp    = 2'b10;
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = st_idle;
      end
      st_addr: begin
        ALUSrc  = 1'b1;
        Reg2Loc = is_stur;
        state_d = is_stur ? st_mem_wr : st_mem_rd;
      end
      st_mem_rd: begin
        ALUSrc  = 1'b1;
        MemRead = 1'b1;
        if (mem_go) begin
          state_d = st_wb_ld;
        end
      end
      st_wb_ld: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = st_idle;
      end
      st_mem_wr: begin
        ALUSrc   = 1'b1;
        Reg2Loc  = 1'b1;
        MemWrite = 1'b1;
        if (mem_go) begin
          retire  = 1'b1;
          state_d = st_idle;
        end
      end
      st_br: begin
        // B and CB-format encodings are disjoint, so is_b alone picks the flavour.
        PCWrite = 1'b1;
        if (is_b) begin
          UncondBranch = 1'b1;
        end else begin
          Branch   = 1'b1;
          Reg2Loc  = 1'b1;
          ALUOp    = 2'b01;
          BranchNZ = is_cbnz;
        end
        retire  = 1'b1;
        state_d = st_idle;
      end
      st_ill: begin
        illegal = 1'b1;
        state_d = st_idle;
      end
      default: begin
        state_d = st_idle;
      end
    endcase
  end

endmodule

// File: tb/tb_maindec_mc.sv
// tb_maindec_mc: two maindec_mc instances (default params; MEM_WAIT/EN_CBNZ/EN_B=0, CNT_W=2)
// driven by a directed table, hand sequences for reset abort and counter wrap, and random opcodes.
`timescale 1ns/1ps
module tb_maindec_mc;

  typedef struct packed {
    logic       rdy, irw, r2l, asrc, m2r, rw, mrd, mwr, br;
    logic [1:0] aluop;
    logic       bnz, ub, pcw, ill;
  } ctl_t;

  typedef struct {
    int          d;
    logic [10:0] op;
    int          w;
    int          exp_cyc;
    int          exp_ret;
  } vec_t;

  // instruction classes used by the reference model
  localparam int C_R = 0, C_LD = 1, C_ST = 2, C_CBZ = 3, C_CBNZ = 4, C_B = 5, C_ILL = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic        iv  [2];
  logic [10:0] op  [2];
  logic        mr  [2];
  logic        rdy [2], irw [2], r2l [2], asrc [2], m2r [2], rw [2];
  logic        mrd [2], mwr [2], br [2], bnz [2], ub [2], pcw [2], ill [2];
  logic [1:0]  aluop [2];
  logic [15:0] ret0;
  logic [1:0]  ret1;

  int checks = 0;
  int errors = 0;
  int cnt [2];
  vec_t tab [19];

  maindec_mc #(.MEM_WAIT(1'b1), .EN_CBNZ(1'b1), .EN_B(1'b1), .CNT_W(16)) u0 (
    .clk(clk), .reset(rst[0]), .instr_valid(iv[0]), .Op(op[0]), .mem_ready(mr[0]),
    .instr_ready(rdy[0]), .IRWrite(irw[0]), .Reg2Loc(r2l[0]), .ALUSrc(asrc[0]),
    .MemtoReg(m2r[0]), .RegWrite(rw[0]), .MemRead(mrd[0]), .MemWrite(mwr[0]),
    .Branch(br[0]), .ALUOp(aluop[0]), .BranchNZ(bnz[0]), .UncondBranch(ub[0]),
    .PCWrite(pcw[0]), .illegal(ill[0]), .retired(ret0));

  maindec_mc #(.MEM_WAIT(1'b0), .EN_CBNZ(1'b0), .EN_B(1'b0), .CNT_W(2)) u1 (
    .clk(clk), .reset(rst[1]), .instr_valid(iv[1]), .Op(op[1]), .mem_ready(mr[1]),
    .instr_ready(rdy[1]), .IRWrite(irw[1]), .Reg2Loc(r2l[1]), .ALUSrc(asrc[1]),
    .MemtoReg(m2r[1]), .RegWrite(rw[1]), .MemRead(mrd[1]), .MemWrite(mwr[1]),
    .Branch(br[1]), .ALUOp(aluop[1]), .BranchNZ(bnz[1]), .UncondBranch(ub[1]),
    .PCWrite(pcw[1]), .illegal(ill[1]), .retired(ret1));

  function automatic int classify(input int d, input logic [10:0] o);
    if (o == 11'b10001011000 || o == 11'b11001011000 ||
        o == 11'b10001010000 || o == 11'b10101010000) return C_R;
    if (o == 11'b11111000010) return C_LD;
    if (o == 11'b11111000000) return C_ST;
    if (o[10:3] == 8'hB4) return C_CBZ;
    if (o[10:3] == 8'hB5) return (d == 0) ? C_CBNZ : C_ILL;
    if (o[10:5] == 6'b000101) return (d == 0) ? C_B : C_ILL;
    return C_ILL;
  endfunction

  // phases after acceptance until back in IDLE
  function automatic int n_phases(input int cls, input int d, input int w);
    int memlen;
    memlen = (d == 0) ? w + 1 : 1;
    case (cls)
      C_R:     return 3;
      C_LD:    return 3 + memlen;
      C_ST:    return 2 + memlen;
      default: return 2;
    endcase
  endfunction

  // expected controls in phase k (0 = decode) of an n-phase instruction of class cls
  function automatic ctl_t phase_ctl(input int cls, input int k, input int n);
    ctl_t e;
    e = '0;
    if (k == 0) return e;
    case (cls)
      C_R: begin
        e.aluop = 2'b10;
        e.rw    = (k == 2);
      end
      C_LD: begin
        if (k == n - 1) begin
          e.m2r = 1'b1;
          e.rw  = 1'b1;
        end else begin
          e.asrc = 1'b1;
          e.mrd  = (k >= 2);
        end
      end
      C_ST: begin
        e.asrc = 1'b1;
        e.r2l  = 1'b1;
        e.mwr  = (k >= 2);
      end
      C_CBZ, C_CBNZ: begin
        e.pcw   = 1'b1;
        e.br    = 1'b1;
        e.r2l   = 1'b1;
        e.aluop = 2'b01;
        e.bnz   = (cls == C_CBNZ);
      end
      C_B: begin
        e.pcw = 1'b1;
        e.ub  = 1'b1;
      end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  function automatic ctl_t get_ctl(input int d);
    ctl_t c;
    c.rdy = rdy[d];  c.irw = irw[d];  c.r2l = r2l[d];  c.asrc = asrc[d];
    c.m2r = m2r[d];  c.rw = rw[d];    c.mrd = mrd[d];  c.mwr = mwr[d];
    c.br = br[d];    c.aluop = aluop[d]; c.bnz = bnz[d]; c.ub = ub[d];
    c.pcw = pcw[d];  c.ill = ill[d];
    return c;
  endfunction

  function automatic int get_ret(input int d);
    return (d == 0) ? int'(ret0) : int'(ret1);
  endfunction

  function automatic int mask(input int d);
    return (d == 0) ? 32'hFFFF : 32'h3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Called just after a rising edge with the DUT in IDLE; returns just after the
  // edge that brings it back to IDLE, so consecutive calls run back-to-back.
  task automatic run_instr(input int d, input logic [10:0] o, input int w,
                           input int abort_at, output int lowcyc);
    int   cls, n, lastmem;
    ctl_t e;
    cls = classify(d, o);
    n   = n_phases(cls, d, w);
    lastmem = (cls == C_LD) ? n - 2 : n - 1;
    iv[d] = 1'b1;
    op[d] = o;
    mr[d] = 1'($urandom);
    @(negedge clk);
    e = '0;
    e.rdy = 1'b1;
    e.irw = 1'b1;
    chk("accept_ctl", 32'(get_ctl(d)), 32'(e));
    chk("accept_ret", 32'(get_ret(d)), 32'(cnt[d]));
    lowcyc = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      iv[d] = 1'($urandom);
      op[d] = 11'($urandom);
      mr[d] = 1'($urandom);
      if (d == 0 && (cls == C_LD || cls == C_ST) && k >= 2 && k <= lastmem)
        mr[d] = (k == lastmem);
      if (k == abort_at) begin
        rst[d] = 1'b0;
        iv[d]  = 1'b0;
        @(negedge clk);
        e = '0;
        e.rdy = 1'b1;
        chk("abort_ctl", 32'(get_ctl(d)), 32'(e));
        chk("abort_ret", 32'(get_ret(d)), 32'd0);
        cnt[d] = 0;
        @(posedge clk);
        #1;
        rst[d] = 1'b1;
        @(negedge clk);
        chk("abort_after", 32'(get_ctl(d)), 32'(e));
        @(posedge clk);
        #1;
        return;
      end
      @(negedge clk);
      if (!rdy[d]) lowcyc++;
      chk("phase_ctl", 32'(get_ctl(d)), 32'(phase_ctl(cls, k, n)));
      chk("busy_ret", 32'(get_ret(d)), 32'(cnt[d]));
    end
    @(posedge clk);
    #1;
    iv[d] = 1'b0;
    if (cls != C_ILL) cnt[d] = (cnt[d] + 1) & mask(d);
    chk("done_ret", 32'(get_ret(d)), 32'(cnt[d]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    int          lc, d, sel, w, n;
    logic [10:0] o, r;
    ctl_t        e;

    tab[0]  = '{0, 11'b10001011000, 0, 3, 1};   // ADD
    tab[1]  = '{0, 11'b11111000010, 3, 7, 2};   // LDUR, 3 wait cycles
    tab[2]  = '{0, 11'b11111000000, 0, 3, 3};   // STUR, ready on entry
    tab[3]  = '{0, 11'b10110100000, 0, 2, 4};   // CBZ back-to-back
    tab[4]  = '{0, 11'b10110101000, 0, 2, 5};   // CBNZ
    tab[5]  = '{0, 11'b00010100000, 0, 2, 6};   // B
    tab[6]  = '{0, 11'b11111111111, 0, 2, 6};   // illegal
    tab[7]  = '{0, 11'b11001011000, 0, 3, 7};   // SUB
    tab[8]  = '{0, 11'b10001010000, 0, 3, 8};   // AND
    tab[9]  = '{0, 11'b10101010000, 0, 3, 9};   // ORR
    tab[10] = '{0, 11'b11111000000, 2, 5, 10};  // STUR, 2 wait cycles
    tab[11] = '{1, 11'b11111000010, 3, 4, 1};   // LDUR, no-wait instance
    tab[12] = '{1, 11'b10110101000, 0, 2, 1};   // CBNZ disabled
    tab[13] = '{1, 11'b00010100000, 0, 2, 1};   // B disabled
    tab[14] = '{1, 11'b10001011000, 0, 3, 2};
    tab[15] = '{1, 11'b10001011000, 0, 3, 3};
    tab[16] = '{1, 11'b10001011000, 0, 3, 0};   // 2-bit wrap
    tab[17] = '{1, 11'b10001011000, 0, 3, 1};
    tab[18] = '{1, 11'b11111000000, 2, 3, 2};   // STUR, wait ignored

    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b0;
      iv[i]  = 1'b1;
      op[i]  = '0;
      mr[i]  = 1'b0;
      cnt[i] = 0;
    end
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      e = '0;
      e.rdy = 1'b1;
      e.irw = 1'b1;
      chk("reset_ctl", 32'(get_ctl(i)), 32'(e));
      chk("reset_ret", 32'(get_ret(i)), 32'd0);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1;
      iv[i]  = 1'b0;
    end

    for (int i = 0; i < 19; i++) begin
      run_instr(tab[i].d, tab[i].op, tab[i].w, -1, lc);
      chk("tab_cycles", 32'(lc), 32'(tab[i].exp_cyc));
      chk("tab_ret", 32'(get_ret(tab[i].d)), 32'(tab[i].exp_ret));
    end

    // Fresh 2-bit counter: five R-types read 1,2,3,0,1, then reset during MEM_RD.
    rst[1] = 1'b0;
    @(negedge clk);
    chk("rst1_ret", 32'(get_ret(1)), 32'd0);
    @(posedge clk);
    #1;
    rst[1] = 1'b1;
    cnt[1] = 0;
    for (int i = 0; i < 5; i++) begin
      run_instr(1, 11'b11001011000, 0, -1, lc);
      chk("wrap_ret", 32'(get_ret(1)), 32'((i + 1) % 4));
    end
    run_instr(1, 11'b11111000010, 0, 2, lc);
    chk("abort1_ret", 32'(get_ret(1)), 32'd0);
    run_instr(0, 11'b11111000010, 3, 3, lc);
    chk("abort0_ret", 32'(get_ret(0)), 32'd0);
    run_instr(0, 11'b10001011000, 0, -1, lc);
    chk("post_abort_ret", 32'(get_ret(0)), 32'd1);

    for (int i = 0; i < 160; i++) begin
      d   = $urandom_range(0, 1);
      sel = $urandom_range(0, 9);
      w   = $urandom_range(0, 4);
      r   = 11'($urandom);
      case (sel)
        0: o = 11'b10001011000;
        1: o = 11'b11001011000;
        2: o = 11'b10001010000;
        3: o = 11'b10101010000;
        4: o = 11'b11111000010;
        5: o = 11'b11111000000;
        6: o = {8'hB4, r[2:0]};
        7: o = {8'hB5, r[2:0]};
        8: o = {6'b000101, r[4:0]};
        default: o = r;
      endcase
      n = n_phases(classify(d, o), d, w);
      run_instr(d, o, w, -1, lc);
      chk("rnd_cycles", 32'(lc), 32'(n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/maindec_mc.md
# maindec_mc

Multicycle main control unit for the LEGv8 datapath: the sequential successor of the single-cycle `maindec`. It accepts one 11-bit opcode per handshake, latches it, and steps through per-class states, driving the same control signals (`Reg2Loc`, `ALUSrc`, `MemtoReg`, `RegWrite`, `MemRead`, `MemWrite`, `Branch`, `ALUOp`) one phase at a time. It adds optional CBNZ/B support, variable-latency memory wait, illegal-opcode detection and a retired-instruction counter. It sits between the fetch stage and the multicycle datapath.

## Interface
- `MEM_WAIT`, default 1: 1 = memory states hold until `mem_ready`; 0 = memory states last exactly one cycle and `mem_ready` is ignored.
- `EN_CBNZ`, default 1: 1 = decode CBNZ; 0 = CBNZ is illegal.
- `EN_B`, default 1: 1 = decode unconditional B; 0 = B is illegal.
- `CNT_W`, default 16: width of `retired`.
- `clk  in  1`: clock, rising edge.
- `reset  in  1`: asynchronous, active-low reset (0 = reset).
- `instr_valid  in  1`: fetch presents a valid opcode.
- `Op  in  11`: opcode, instr[31:21].
- `mem_ready  in  1`: data memory completes the current access.
- `instr_ready  out  1`: unit is idle and accepts an opcode.
- `IRWrite  out  1`: latch the instruction register.
- `Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch  out  1 each`: datapath controls, same meaning as in `maindec`.
- `ALUOp  out  2`: 00 add, 01 pass-B/zero test, 10 R-type funct.
- `BranchNZ  out  1`: branch condition is "not zero" (CBNZ).
- `UncondBranch  out  1`: take branch unconditionally (B).
- `PCWrite  out  1`: commit the branch target to the PC.
- `illegal  out  1`: one-cycle pulse on an undecodable opcode.
- `retired  out  CNT_W`: count of completed legal instructions.

## Operation
- Opcodes: LDUR 11111000010, STUR 11111000000, ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, CBZ 10110100xxx, CBNZ 10110101xxx, B 000101xxxxx. Anything else is illegal.
- Opcode is latched into `op_q` on acceptance. All outputs are Moore functions of state and `op_q`. Signals not listed for a state are 0.
- IDLE: `instr_ready`=1. If `instr_valid`=1, `IRWrite`=1 in this cycle, latch `Op`, go to DECODE. Otherwise stay.
- DECODE: classify `op_q`. R-type goes to EXEC_R. LDUR/STUR go to ADDR. CBZ, enabled CBNZ and enabled B go to BR. Otherwise go to ILL.
- EXEC_R: `ALUOp`=10. Go to WB_R.
- WB_R: `ALUOp`=10, `RegWrite`=1. Retire, go to IDLE.
- ADDR: `ALUSrc`=1, `ALUOp`=00, `Reg2Loc`=1 if STUR. Go to MEM_RD for LDUR, MEM_WR for STUR.
- MEM_RD: `ALUSrc`=1, `MemRead`=1. Advance to WB_LD when `mem_ready` or `MEM_WAIT`=0; otherwise hold.
- WB_LD: `MemtoReg`=1, `RegWrite`=1. Retire, go to IDLE.
- MEM_WR: `ALUSrc`=1, `Reg2Loc`=1, `MemWrite`=1. Leave when `mem_ready` or `MEM_WAIT`=0, then retire and go to IDLE.
- BR:
  - `PCWrite`=1.
  - CBZ/CBNZ: `Branch`=1, `Reg2Loc`=1, `ALUOp`=01; CBNZ also sets `BranchNZ`=1.
  - B: `UncondBranch`=1.
  - Retire, go to IDLE.
- ILL: `illegal`=1. Go to IDLE; not retired.
- "Retire": `retired` increments by 1 on the clock edge leaving the state, wrapping modulo 2^CNT_W.
- `instr_valid` outside IDLE is ignored; fetch must hold the opcode until accepted.

## Timing
- Reset (async, `reset`=0):
  - state=IDLE, `op_q`=0, `retired`=0.
  - Outputs: `instr_ready`=1; all others 0, except `IRWrite`, which follows `instr_valid` while in IDLE.
  - Reset mid-instruction aborts with no retire and no further control pulses.
- Cycles from acceptance edge back to IDLE:
  - R-type: 3.
  - LDUR: 4 + memory wait cycles.
  - STUR: 3 + memory wait cycles.
  - Branch: 2.
  - Illegal: 2.
- Back-to-back: an opcode can be accepted in the IDLE cycle immediately after completion. There are no idle bubbles beyond that cycle.
- `mem_ready` already high on entry to MEM_RD/MEM_WR gives a single-cycle access. A held `mem_ready` never skips a state.
- `retired` wraps from 2^CNT_W-1 to 0 without a flag.

## Test plan
- Reset, then ADD (10001011000) with `instr_valid` pulsed. Required: IDLE, DECODE, EXEC_R (`ALUOp`=10), WB_R (`RegWrite`=1), then `instr_ready`=1 three cycles after acceptance; `retired`=1.
- LDUR with `mem_ready` held 0 for 3 cycles in MEM_RD. Required: `MemRead`=1 for 4 cycles, then WB_LD with `MemtoReg`=`RegWrite`=1; `MemWrite` never 1. Repeat with `MEM_WAIT`=0: MEM_RD lasts 1 cycle.
- STUR, then CBZ (10110100000), back-to-back. Required: `Reg2Loc`=1 in ADDR/MEM_WR and `MemWrite`=1. CBZ gives a BR cycle with `Branch`=1, `ALUOp`=01, `PCWrite`=1, `BranchNZ`=0; `retired`=2.
- CBNZ (10110101000) and B (00010100000) with `EN_CBNZ`=`EN_B`=1. Required: `BranchNZ`=1 and `UncondBranch`=1 respectively. With both params at 0, each yields an `illegal` pulse and `retired` unchanged.
- Opcode 11111111111. Required: `illegal`=1 for exactly one cycle two cycles after acceptance, all datapath controls 0, no retire.
- `CNT_W`=2, five R-type instructions. Required: `retired` reads 1,2,3,0,1. Assert `reset`=0 during MEM_RD of a following LDUR: `retired`=0 and state=IDLE immediately, with no `RegWrite`.
